// File: rtl/pc_call_stack.sv
// Return-address stack feeding the PC mux FROM_STACK input.
// CALL pushes PC_COUNT+1, RET exposes the top combinationally for a zero-bubble return.
module pc_call_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    input  logic [AW-1:0]              pc_count,
    output logic [AW-1:0]              from_stack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] sp;

    logic [PW-1:0] top_idx;
    logic [PW-1:0] free_idx;
    logic [PW-1:0] wr_idx;
    logic [AW-1:0] ret_addr;
    logic          do_push;
    logic          do_pop;
    logic          do_replace;
    logic          push_full;
    logic          pop_empty;
    logic          wr_en;

    always_comb begin
        empty      = (sp == '0);
        full       = (sp == CW'(DEPTH));
        count      = sp;
        top_idx    = PW'(sp - CW'(1));
        free_idx   = PW'(sp);
        ret_addr   = pc_count + AW'(1);
        from_stack = empty ? '0 : mem[top_idx];
    end

    // PUSH+POP on an empty stack degenerates to a plain push and raises no flag.
    always_comb begin
        do_push    = push & ~full & (~pop | empty);
        push_full  = push & ~pop & full;
        do_pop     = pop & ~push & ~empty;
        pop_empty  = pop & ~push & empty;
        do_replace = push & pop & ~empty;
        wr_en      = do_push | do_replace;
        wr_idx     = do_replace ? top_idx : free_idx;
    end

    // Storage is deliberately not reset; entries are invisible while the stack is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= ret_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                sp <= sp + CW'(1);
            end else if (do_pop) begin
                sp <= sp - CW'(1);
            end
            // Clearing takes effect first, so an error in the same cycle still sticks.
            overflow  <= (overflow  & ~clr_err) | push_full;
            underflow <= (underflow & ~clr_err) | pop_empty;
        end
    end

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pc_call_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push;
    logic          pop;
    logic          clr_err;
    logic [AW-1:0] pc_count;
    logic [AW-1:0] from_stack;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    // Small PC + mux used by the integration scenario.
    logic          use_pc;
    logic [AW-1:0] pc_drv;
    logic [AW-1:0] pc_reg;
    logic          pc_ld;
    logic          pc_sel_stack;
    logic [AW-1:0] pc_target;

    int tests_run = 0;
    int tests_failed = 0;

    logic [AW-1:0] model_q[$];
    logic          model_ovf;
    logic          model_unf;

    always #5 clk = ~clk;

    assign pc_count = use_pc ? pc_reg : pc_drv;

    always @(posedge clk) begin
        if (pc_ld) pc_reg <= pc_sel_stack ? from_stack : pc_target;
    end

    pc_call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .clr_err    (clr_err),
        .pc_count   (pc_count),
        .from_stack (from_stack),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic model_update(input logic p, input logic o, input logic c, input logic [AW-1:0] pcv);
        logic [AW-1:0] ra;
        ra = pcv + 10'd1;
        if (c) begin
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end
        if (p && !o) begin
            if (model_q.size() < DEPTH) model_q.push_back(ra);
            else model_ovf = 1'b1;
        end else if (o && !p) begin
            if (model_q.size() > 0) void'(model_q.pop_back());
            else model_unf = 1'b1;
        end else if (p && o) begin
            if (model_q.size() > 0) model_q[model_q.size()-1] = ra;
            else model_q.push_back(ra);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    // Drives one cycle of strobes, advances the model, samples 1 time unit after the edge.
    task automatic step(input logic p, input logic o, input logic c, input logic [AW-1:0] pcv);
        push = p;
        pop = o;
        clr_err = c;
        pc_drv = pcv;
        #1;
        model_update(p, o, c, pc_count);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count);
        end
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_empty_full: got empty=%b full=%b expected 1/0", empty, full);
        end
        tests_run++;
        if (from_stack !== 10'h000 || overflow !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got from_stack=%h ovf=%b unf=%b expected 000/0/0",
                     from_stack, overflow, underflow);
        end
    endtask

    task automatic test_push_pop();
        logic [AW-1:0] pcs [3];
        logic [AW-1:0] tops [3];
        pcs = '{10'h010, 10'h020, 10'h030};
        tops = '{10'h021, 10'h011, 10'h000};
        foreach (pcs[i]) step(1'b1, 1'b0, 1'b0, pcs[i]);
        tests_run++;
        if (from_stack !== 10'h031 || count !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL push3: got from_stack=%h count=%0d expected 031/3", from_stack, count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 10'h3AA);
            tests_run++;
            if (from_stack !== tops[i]) begin
                tests_failed++;
                $display("[TB] FAIL pop%0d_top: got %h expected %h", i, from_stack, tops[i]);
            end
        end
        tests_run++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL pop_empty: got empty=%b count=%0d expected 1/0", empty, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, AW'(i));
        tests_run++;
        if (full !== 1'b1 || from_stack !== 10'h008) begin
            tests_failed++;
            $display("[TB] FAIL fill: got full=%b from_stack=%h expected 1/008", full, from_stack);
        end
        step(1'b1, 1'b0, 1'b0, 10'h155);
        tests_run++;
        if (overflow !== 1'b1 || count !== 4'd8 || from_stack !== 10'h008) begin
            tests_failed++;
            $display("[TB] FAIL overflow: got ovf=%b count=%0d from_stack=%h expected 1/8/008",
                     overflow, count, from_stack);
        end
        step(1'b0, 1'b0, 1'b1, 10'h000);
        tests_run++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            tests_failed++;
            $display("[TB] FAIL clr_overflow: got ovf=%b count=%0d expected 0/8", overflow, count);
        end
    endtask

    task automatic test_replace_full();
        step(1'b1, 1'b1, 1'b0, 10'h3FF);
        tests_run++;
        if (count !== 4'd8 || from_stack !== 10'h000 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL replace_full: got count=%0d top=%h ovf=%b expected 8/000/0",
                     count, from_stack, overflow);
        end
        step(1'b0, 1'b1, 1'b0, 10'h000);
        tests_run++;
        if (from_stack !== 10'h007 || count !== 4'd7) begin
            tests_failed++;
            $display("[TB] FAIL replace_below: got top=%h count=%0d expected 007/7", from_stack, count);
        end
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 10'h000);
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 1'b0, 10'h000);
        tests_run++;
        if (underflow !== 1'b1 || count !== 4'd0 || from_stack !== 10'h000) begin
            tests_failed++;
            $display("[TB] FAIL underflow: got unf=%b count=%0d from_stack=%h expected 1/0/000",
                     underflow, count, from_stack);
        end
        step(1'b1, 1'b1, 1'b0, 10'h100);
        tests_run++;
        if (count !== 4'd1 || from_stack !== 10'h101 || underflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pushpop_empty: got count=%0d top=%h unf=%b expected 1/101/1",
                     count, from_stack, underflow);
        end
        // A clear and a new error in the same cycle must leave the flag set.
        step(1'b0, 1'b1, 1'b0, 10'h000);
        step(1'b0, 1'b1, 1'b1, 10'h000);
        tests_run++;
        if (underflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clr_with_new_err: got unf=%b expected 1", underflow);
        end
        step(1'b0, 1'b0, 1'b1, 10'h000);
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL clr_underflow: got unf=%b expected 0", underflow);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 10'h0A0);
        step(1'b1, 1'b0, 1'b0, 10'h0B0);
        tests_run++;
        if (count !== 4'd2) begin
            tests_failed++;
            $display("[TB] FAIL async_pre: got count=%0d expected 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (count !== 4'd0 || empty !== 1'b1 || from_stack !== 10'h000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got count=%0d empty=%b from_stack=%h expected 0/1/000",
                     count, empty, from_stack);
        end
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_pc_integration();
        use_pc = 1'b1;
        pc_ld = 1'b1;
        pc_sel_stack = 1'b0;
        pc_target = 10'h050;
        @(posedge clk);
        #1;
        pc_target = 10'h200;
        step(1'b1, 1'b0, 1'b0, 10'h000);
        tests_run++;
        if (pc_reg !== 10'h200 || from_stack !== 10'h051) begin
            tests_failed++;
            $display("[TB] FAIL call: got pc=%h from_stack=%h expected 200/051", pc_reg, from_stack);
        end
        pc_sel_stack = 1'b1;
        step(1'b0, 1'b1, 1'b0, 10'h000);
        pc_ld = 1'b0;
        pc_sel_stack = 1'b0;
        use_pc = 1'b0;
        tests_run++;
        if (pc_reg !== 10'h051 || empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ret: got pc=%h empty=%b expected 051/1", pc_reg, empty);
        end
    endtask

    task automatic test_random();
        int r;
        logic p, o, c;
        logic [AW-1:0] exp_top;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            p = (r <= 3) || (r == 7) || (r == 8);
            o = (r >= 4 && r <= 8);
            c = ($urandom_range(0, 7) == 0);
            step(p, o, c, AW'($urandom));
            exp_top = (model_q.size() > 0) ? model_q[model_q.size()-1] : 10'h000;
            tests_run++;
            if (count !== 4'(model_q.size()) || from_stack !== exp_top ||
                empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH) ||
                overflow !== model_ovf || underflow !== model_unf) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d: got count=%0d top=%h e=%b f=%b ovf=%b unf=%b expected count=%0d top=%h ovf=%b unf=%b",
                         n, count, from_stack, empty, full, overflow, underflow,
                         model_q.size(), exp_top, model_ovf, model_unf);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        clr_err = 1'b0;
        pc_drv = '0;
        use_pc = 1'b0;
        pc_ld = 1'b0;
        pc_sel_stack = 1'b0;
        pc_target = '0;
        model_reset();
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_push_pop();
        test_fill_overflow();
        test_replace_full();
        test_underflow();
        test_async_reset();
        test_pc_integration();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Hardware return-address stack that sources the program counter's FROM_STACK input. On a CALL it captures the return address (current PC_COUNT + 1). On a RET it presents the saved address so the PC mux can select it and the PC can load it in the same cycle. It sits beside the control unit, upstream of the PC mux, and consumes PC_COUNT from the program counter.

## Interface
Parameters:
- DEPTH, 8, number of 10-bit return-address entries; must be a power of 2, minimum 2
- AW, 10, address width; must match PC_COUNT

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RST_N  input  1  asynchronous, active-low reset
- PUSH  input  1  CALL strobe from the control unit; single-cycle
- POP  input  1  RET strobe from the control unit; single-cycle
- CLR_ERR  input  1  synchronous clear of the sticky error flags
- PC_COUNT  input  AW  current program counter value
- FROM_STACK  output  AW  top-of-stack return address; drives PC mux input
- COUNT  output  $clog2(DEPTH)+1  number of valid entries
- EMPTY  output  1  COUNT == 0
- FULL  output  1  COUNT == DEPTH
- OVERFLOW  output  1  sticky: a PUSH was attempted while FULL
- UNDERFLOW  output  1  sticky: a POP was attempted while EMPTY

## Operation
- Storage: DEPTH x AW register array, plus stack pointer SP (== COUNT). The next free slot is mem[SP]; the top is mem[SP-1].
- Return address: PC_COUNT + 1, computed modulo 2^AW, so 10'h3FF pushes 10'h000.
- FROM_STACK is combinational from the registered state:
  - mem[SP-1] when not EMPTY
  - 0 when EMPTY
- Per rising edge, priority order:
  - CLR_ERR = 1: OVERFLOW <= 0 and UNDERFLOW <= 0. This is evaluated before any new error is set in the same cycle, so a new error still sets its flag.
  - PUSH = 1, POP = 0, not FULL: mem[SP] <= PC_COUNT + 1; SP <= SP + 1.
  - PUSH = 1, POP = 0, FULL: no storage change; OVERFLOW <= 1.
  - POP = 1, PUSH = 0, not EMPTY: SP <= SP - 1. The popped entry is not cleared.
  - POP = 1, PUSH = 0, EMPTY: no change; UNDERFLOW <= 1.
  - PUSH = 1, POP = 1, not EMPTY: replace the top (mem[SP-1] <= PC_COUNT + 1); SP unchanged. Legal even when FULL; no flag is set.
  - PUSH = 1, POP = 1, EMPTY: behaves as a plain push; UNDERFLOW is not set.
- Reset (RST_N low, asynchronous): SP = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Resulting outputs: EMPTY = 1, FULL = 0, COUNT = 0, FROM_STACK = 0.
  - Array contents are not reset; they are unobservable while empty.
  - A reset asserted mid-operation discards all entries immediately, without waiting for CLK.
- There is no wrap-around of SP. Full and empty conditions are handled only through the flags above.

## Timing
- PUSH: the entry is visible on FROM_STACK, and COUNT/FULL/EMPTY update, in the cycle after the edge that samples PUSH.
- POP / RET flow, all in one cycle:
  - The control unit asserts POP together with PC_MUX_SEL = stack and PC_LD = 1.
  - FROM_STACK already holds the return address before the edge, so the PC loads it on that same edge.
  - SP decrements on that same edge. Zero-latency read; no bubble.
- CALL flow: PUSH is asserted in the same cycle as the PC load of the immediate target. The PC_COUNT sampled is the address of the CALL instruction.
- FROM_STACK, COUNT, FULL and EMPTY never glitch on CLK edges without a state change. Flags are registered.
- Reset deassertion is synchronized externally. Release may occur on any edge; the first operation is accepted on the following rising edge.

## Test plan
- Reset, then 3 pushes with PC_COUNT = 10'h010, 10'h020, 10'h030 -> FROM_STACK = 10'h031, COUNT = 3; 3 pops -> FROM_STACK = 10'h021, then 10'h011, then 0 with EMPTY = 1.
- Fill to DEPTH = 8 with PC_COUNT = 0..7 -> FULL = 1, FROM_STACK = 10'h008; a 9th push -> OVERFLOW = 1, COUNT stays 8, FROM_STACK stays 10'h008; CLR_ERR -> OVERFLOW = 0.
- Pop while empty -> UNDERFLOW = 1, COUNT = 0, FROM_STACK = 0; PUSH + POP together while empty with PC_COUNT = 10'h100 -> COUNT = 1, FROM_STACK = 10'h101, UNDERFLOW stays 1.
- PUSH + POP together when FULL with PC_COUNT = 10'h3FF -> COUNT = 8, top = 10'h000 (wrap), OVERFLOW stays 0.
- With 2 entries, assert RST_N low between clock edges -> COUNT = 0, EMPTY = 1, FROM_STACK = 0 before the next CLK edge.
- Integrated with the PC and PC mux: CALL at 10'h050 to 10'h200, then RET with POP + PC_LD + stack select -> PC_COUNT = 10'h051 on the next edge; stack EMPTY.
